multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multi-cycle successor to the single-cycle MIPS control decoder. A 5-state FSM (FETCH/DECODE/EXEC/MEM/WB) sequences each instruction and drives datapath strobes per state. Memory-mapped I/O decode is generalised by parameter, and data/IO accesses wait on an ack handshake with a timeout. Sits between IFetch/IR, register file, ALU and the memory/IO bus.

Parameters:
ADDR_HIGH_WIDTH, 22, width of Alu_resultHigh (address bits above the page offset)
IO_PAGE, 22'h3FFFFF, Alu_resultHigh value selecting I/O instead of memory
TIMEOUT, 15, max cycles in MEM waiting for ack before bus error (1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Opcode  in  6  IR[31:26], valid from DECODE onward
Function_opcode  in  6  IR[5:0]
Alu_resultHigh  in  ADDR_HIGH_WIDTH  ALU result high bits, valid in EXEC
mem_ack  in  1  data memory access complete
io_ack  in  1  I/O access complete
IRWrite, PCWrite  out  1 each  load IR; PC<=PC+4
Jmp, Jal, Jr, Branch, nBranch  out  1 each  PC-source selects
RegDST, ALUSrc, Sftmd  out  1 each  same meaning as the single-cycle decoder
ALUOp  out  2  {R_format|I_format, Branch|nBranch}
RegWrite, MemorIOtoReg  out  1 each  register write strobe; write-data select memory/IO
MemRead, MemWrite, IORead, IOWrite  out  1 each  bus access strobes
bus_error  out  1  one-cycle pulse on MEM timeout
illegal_instr  out  1  one-cycle pulse on unknown opcode
instr_done  out  1  one-cycle pulse on the last cycle of every instruction
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4

Behaviour:
- Opcodes: R=000000 (JR: func 001000), LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, JAL=000011, I_format = Opcode[5:3]==001. Sftmd for R funcs 000000/000010/000011/000100/000110/000111.
- Reset: state=FETCH, every output 0, wait counter 0, latched is_io 0. Reset in any state, including MEM mid-wait, aborts immediately; no strobe asserted on the reset cycle or the cycle after.
- FETCH (1 cycle): IRWrite=1, PCWrite=1 -> DECODE.
- DECODE: J: Jmp=1, instr_done -> FETCH. JAL: Jal=1, RegWrite=1, instr_done -> FETCH. JR: Jr=1, instr_done -> FETCH. Otherwise -> EXEC.
- EXEC: ALUSrc, ALUOp, Sftmd, RegDST driven from the opcode. BEQ/BNE: Branch/nBranch=1, instr_done -> FETCH. R/I_format -> WB. LW/SW: latch is_io = (Alu_resultHigh==IO_PAGE) -> MEM. Any other opcode: illegal_instr=1, instr_done -> FETCH; no write strobes.
- MEM: exactly one of MemRead/MemWrite/IORead/IOWrite held high (op + is_io) every cycle until ack. The ack is taken only from the selected target (mem_ack if !is_io, else io_ack); the other ack is ignored. Counter increments each MEM cycle without ack. Ack arrives on cycle k (k<=TIMEOUT, first MEM cycle = 1): SW -> FETCH with instr_done; LW -> WB. No ack after TIMEOUT cycles: bus_error=1, instr_done=1 -> FETCH; an LW skips WB (no register write). Counter clears on leaving MEM.
- WB (1 cycle): RegWrite=1; MemorIOtoReg=1 for LW; RegDST=1 for R; instr_done -> FETCH.
- RegWrite is never asserted for JR. Strobes are Moore-decoded from state + opcode and carry no extra latency.
- CPI: J/JAL/JR=2, BEQ/BNE=3, R/I=4, SW=3+k, LW=4+k.

Test Plan:
- reset high 2 cycles mid-MEM (LW, no ack) -> state=0, all strobes 0, no RegWrite, next instr starts FETCH.
- R add (Opcode 0, func 100000) -> states 0,1,2,4; RegDST=1, RegWrite=1 in WB only; instr_done at cycle 4.
- LW, Alu_resultHigh=3FFFFF, io_ack on 3rd MEM cycle -> IORead high 3 cycles, MemRead 0, then WB with MemorIOtoReg=1; 7 cycles total.
- SW, Alu_resultHigh=0, mem_ack held 0 -> MemWrite high 15 cycles, bus_error pulse on 15th, then FETCH; io_ack=1 during the wait is ignored.
- BNE then JAL back-to-back -> nBranch=1 in EXEC (3 cycles); Jal=1 and RegWrite=1 in DECODE (2 cycles).
- Opcode 111111 -> illegal_instr pulse in EXEC, no RegWrite/MemWrite, return to FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS control FSM with memory/IO bus handshake and timeout
`timescale 1ns/1ps
module multicycle_controller #(
    parameter int                         ADDR_HIGH_WIDTH = 22,
    parameter logic [ADDR_HIGH_WIDTH-1:0] IO_PAGE         = 22'h3FFFFF,
    parameter int                         TIMEOUT         = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [5:0]                 Opcode,
    input  logic [5:0]                 Function_opcode,
    input  logic [ADDR_HIGH_WIDTH-1:0] Alu_resultHigh,
    input  logic                       mem_ack,
    input  logic                       io_ack,
    output logic                       IRWrite,
    output logic                       PCWrite,
    output logic                       Jmp,
    output logic                       Jal,
    output logic                       Jr,
    output logic                       Branch,
    output logic                       nBranch,
    output logic                       RegDST,
    output logic                       ALUSrc,
    output logic                       Sftmd,
    output logic [1:0]                 ALUOp,
    output logic                       RegWrite,
    output logic                       MemorIOtoReg,
    output logic                       MemRead,
    output logic                       MemWrite,
    output logic                       IORead,
    output logic                       IOWrite,
    output logic                       bus_error,
    output logic                       illegal_instr,
    output logic                       instr_done,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // last wait-count value before a missing ack becomes a bus error
    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic       r_is_io;
    logic       r_rst_hold;

    logic w_op_r, w_op_jr, w_op_lw, w_op_sw, w_op_beq, w_op_bne;
    logic w_op_j, w_op_jal, w_op_i, w_sft;
    logic w_ack, w_timeout, w_quiet;

    assign w_op_r   = (Opcode == 6'b000000);
    assign w_op_jr  = w_op_r && (Function_opcode == 6'b001000);
    assign w_op_lw  = (Opcode == 6'b100011);
    assign w_op_sw  = (Opcode == 6'b101011);
    assign w_op_beq = (Opcode == 6'b000100);
    assign w_op_bne = (Opcode == 6'b000101);
    assign w_op_j   = (Opcode == 6'b000010);
    assign w_op_jal = (Opcode == 6'b000011);
    assign w_op_i   = (Opcode[5:3] == 3'b001);
    assign w_sft    = w_op_r && ((Function_opcode == 6'b000000) || (Function_opcode == 6'b000010) ||
                                 (Function_opcode == 6'b000011) || (Function_opcode == 6'b000100) ||
                                 (Function_opcode == 6'b000110) || (Function_opcode == 6'b000111));

    // only the ack of the latched target counts; the other bus is ignored
    assign w_ack     = r_is_io ? io_ack : mem_ack;
    assign w_timeout = !w_ack && (r_wait_cnt == LP_TMO_LAST);
    // strobes are silenced while reset is high and for one settle cycle after it
    assign w_quiet   = reset || r_rst_hold;
    assign state     = r_state;

    // state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // bus wait counter, IO-target latch and post-reset hold flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
            r_is_io    <= 1'b0;
            r_rst_hold <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
            if (r_state == S_MEM && !w_ack && !w_timeout) r_wait_cnt <= r_wait_cnt + 8'd1;
            else                                          r_wait_cnt <= 8'd0;
            if (r_state == S_EXEC && (w_op_lw || w_op_sw))
                r_is_io <= (Alu_resultHigh == IO_PAGE);
        end
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        if (r_rst_hold) begin
            w_next = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  w_next = S_DECODE;
                S_DECODE: w_next = (w_op_j || w_op_jal || w_op_jr) ? S_FETCH : S_EXEC;
                S_EXEC: begin
                    if (w_op_beq || w_op_bne)    w_next = S_FETCH;
                    else if (w_op_r || w_op_i)   w_next = S_WB;
                    else if (w_op_lw || w_op_sw) w_next = S_MEM;
                    else                         w_next = S_FETCH;
                end
                S_MEM: begin
                    if (w_ack)          w_next = w_op_lw ? S_WB : S_FETCH;
                    else if (w_timeout) w_next = S_FETCH;
                    else                w_next = S_MEM;
                end
                S_WB:     w_next = S_FETCH;
                default:  w_next = S_FETCH;
            endcase
        end
    end

    // datapath strobes decoded from state and opcode
    always_comb begin
        IRWrite = 1'b0; PCWrite = 1'b0; Jmp = 1'b0; Jal = 1'b0; Jr = 1'b0;
        Branch = 1'b0; nBranch = 1'b0; RegDST = 1'b0; ALUSrc = 1'b0; Sftmd = 1'b0;
        ALUOp = 2'b00; RegWrite = 1'b0; MemorIOtoReg = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; IORead = 1'b0; IOWrite = 1'b0;
        bus_error = 1'b0; illegal_instr = 1'b0; instr_done = 1'b0;
        if (!w_quiet) begin
            case (r_state)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                S_DECODE: begin
                    if (w_op_j) begin
                        Jmp = 1'b1; instr_done = 1'b1;
                    end else if (w_op_jal) begin
                        Jal = 1'b1; RegWrite = 1'b1; instr_done = 1'b1;
                    end else if (w_op_jr) begin
                        Jr = 1'b1; instr_done = 1'b1;
                    end
                end
                S_EXEC: begin
                    ALUSrc = w_op_i || w_op_lw || w_op_sw;
                    ALUOp  = {w_op_r || w_op_i, w_op_beq || w_op_bne};
                    Sftmd  = w_sft;
                    RegDST = w_op_r;
                    if (w_op_beq || w_op_bne) begin
                        Branch = w_op_beq; nBranch = w_op_bne; instr_done = 1'b1;
                    end else if (!(w_op_r || w_op_i || w_op_lw || w_op_sw)) begin
                        illegal_instr = 1'b1; instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    MemRead  = w_op_lw && !r_is_io;
                    IORead   = w_op_lw &&  r_is_io;
                    MemWrite = w_op_sw && !r_is_io;
                    IOWrite  = w_op_sw &&  r_is_io;
                    if (w_ack) begin
                        instr_done = w_op_sw;
                    end else if (w_timeout) begin
                        bus_error = 1'b1; instr_done = 1'b1;
                    end
                end
                S_WB: begin
                    RegWrite     = 1'b1;
                    MemorIOtoReg = w_op_lw;
                    RegDST       = w_op_r;
                    instr_done   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
`timescale 1ns/1ps
module tb_multicycle_controller;

    localparam int TMO = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  Opcode, Function_opcode;
    logic [21:0] Alu_resultHigh;
    logic        mem_ack, io_ack;
    logic IRWrite, PCWrite, Jmp, Jal, Jr, Branch, nBranch, RegDST, ALUSrc, Sftmd;
    logic [1:0] ALUOp;
    logic RegWrite, MemorIOtoReg, MemRead, MemWrite, IORead, IOWrite;
    logic bus_error, illegal_instr, instr_done;
    logic [2:0] state;

    always #5 clock = ~clock;

    multicycle_controller #(.ADDR_HIGH_WIDTH(22), .IO_PAGE(22'h3FFFFF), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
        .Alu_resultHigh(Alu_resultHigh), .mem_ack(mem_ack), .io_ack(io_ack),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
        .Branch(Branch), .nBranch(nBranch), .RegDST(RegDST), .ALUSrc(ALUSrc), .Sftmd(Sftmd),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .MemorIOtoReg(MemorIOtoReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite),
        .bus_error(bus_error), .illegal_instr(illegal_instr), .instr_done(instr_done),
        .state(state)
    );

    localparam logic [20:0] IRW  = 21'(1) << 20, PCW  = 21'(1) << 19, JMP  = 21'(1) << 18,
                            JAL  = 21'(1) << 17, JR   = 21'(1) << 16, BR   = 21'(1) << 15,
                            NBR  = 21'(1) << 14, RDST = 21'(1) << 13, ASRC = 21'(1) << 12,
                            SFT  = 21'(1) << 11, AOP1 = 21'(1) << 10, AOP0 = 21'(1) << 9,
                            RW   = 21'(1) << 8,  M2R  = 21'(1) << 7,  MR   = 21'(1) << 6,
                            MW   = 21'(1) << 5,  IOR  = 21'(1) << 4,  IOW  = 21'(1) << 3,
                            BERR = 21'(1) << 2,  ILL  = 21'(1) << 1,  DONE = 21'(1);

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

    logic [23:0] obs;
    assign obs = {IRWrite, PCWrite, Jmp, Jal, Jr, Branch, nBranch, RegDST, ALUSrc, Sftmd,
                  ALUOp, RegWrite, MemorIOtoReg, MemRead, MemWrite, IORead, IOWrite,
                  bus_error, illegal_instr, instr_done, state};

    typedef struct packed {
        logic [23:0] vec;
        logic        mack;
        logic        iack;
    } step_t;

    step_t sq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    task automatic push(input logic [20:0] f, input logic [2:0] s, input logic ma, input logic ia);
        step_t e;
        e.vec  = {f, s};
        e.mack = ma;
        e.iack = ia;
        sq.push_back(e);
    endtask

    // expected per-cycle trace of one instruction, with the ack stimulus for each cycle
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input bit io,
                         input int ack_k, input bit other_hi);
        logic [20:0] st;
        logic        ack, ma, ia;
        bit          sft;
        sft = (op == OP_R) && (fn == 6'd0 || fn == 6'd2 || fn == 6'd3 ||
                               fn == 6'd4 || fn == 6'd6 || fn == 6'd7);
        push(IRW | PCW, 3'd0, 1'b0, 1'b0);
        if (op == OP_J)                  begin push(JMP | DONE, 3'd1, 1'b0, 1'b0);      return; end
        if (op == OP_JAL)                begin push(JAL | RW | DONE, 3'd1, 1'b0, 1'b0); return; end
        if (op == OP_R && fn == 6'b001000) begin push(JR | DONE, 3'd1, 1'b0, 1'b0);     return; end
        push(21'd0, 3'd1, 1'b0, 1'b0);
        if (op == OP_BEQ) begin push(AOP0 | BR | DONE, 3'd2, 1'b0, 1'b0);  return; end
        if (op == OP_BNE) begin push(AOP0 | NBR | DONE, 3'd2, 1'b0, 1'b0); return; end
        if (op == OP_R) begin
            push(RDST | AOP1 | (sft ? SFT : 21'd0), 3'd2, 1'b0, 1'b0);
            push(RW | RDST | DONE, 3'd4, 1'b0, 1'b0);
            return;
        end
        if (op[5:3] == 3'b001) begin
            push(ASRC | AOP1, 3'd2, 1'b0, 1'b0);
            push(RW | DONE, 3'd4, 1'b0, 1'b0);
            return;
        end
        if (op == OP_LW || op == OP_SW) begin
            push(ASRC, 3'd2, 1'b0, 1'b0);
            st = (op == OP_LW) ? (io ? IOR : MR) : (io ? IOW : MW);
            for (int k = 1; k <= TMO; k++) begin
                ack = (k == ack_k);
                ma  = io ? other_hi : ack;
                ia  = io ? ack : other_hi;
                if (ack) begin
                    if (op == OP_SW) push(st | DONE, 3'd3, ma, ia);
                    else begin
                        push(st, 3'd3, ma, ia);
                        push(RW | M2R | DONE, 3'd4, 1'b0, 1'b0);
                    end
                    return;
                end else if (k == TMO) push(st | BERR | DONE, 3'd3, ma, ia);
                else                   push(st, 3'd3, ma, ia);
            end
            return;
        end
        push(ILL | DONE, 3'd2, 1'b0, 1'b0);
    endtask

    task automatic setup(input logic [5:0] op, input logic [5:0] fn, input logic [21:0] hi);
        Opcode = op; Function_opcode = fn; Alu_resultHigh = hi;
    endtask

    // drain the scoreboard one clock per entry, comparing away from the rising edge
    task automatic run(input string tag);
        step_t e;
        while (sq.size() > 0) begin
            e = sq.pop_front();
            mem_ack = e.mack;
            io_ack  = e.iack;
            #1;
            checks++;
            assert (obs === e.vec) else begin
                errors++;
                $error("FAIL %s cyc%0d obs=%h exp=%h", tag, cyc, obs, e.vec);
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        mem_ack = 1'b0;
        io_ack  = 1'b0;
    endtask

    // two reset cycles followed by the quiet settle cycle; all strobes must stay low
    task automatic do_reset(input string tag);
        reset = 1'b1; mem_ack = 1'b0; io_ack = 1'b0;
        #1;
        checks++;
        assert (obs[23:3] === 21'd0) else begin
            errors++;
            $error("FAIL %s_rst0 obs=%h exp=%h", tag, obs[23:3], 21'd0);
        end
        @(posedge clock); @(negedge clock);
        #1;
        checks++;
        assert (obs === 24'd0) else begin
            errors++;
            $error("FAIL %s_rst1 obs=%h exp=%h", tag, obs, 24'd0);
        end
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        assert (obs === 24'd0) else begin
            errors++;
            $error("FAIL %s_rst2 obs=%h exp=%h", tag, obs, 24'd0);
        end
        @(posedge clock); @(negedge clock);
    endtask

    initial begin
        setup(OP_R, 6'd0, 22'd0);
        do_reset("init");

        setup(OP_R, 6'b100000, 22'd0);      model(OP_R, 6'b100000, 1'b0, 0, 1'b0);    run("r_add");
        setup(OP_R, 6'b000000, 22'd0);      model(OP_R, 6'b000000, 1'b0, 0, 1'b0);    run("r_sll");
        setup(OP_ADDI, 6'd0, 22'd0);        model(OP_ADDI, 6'd0, 1'b0, 0, 1'b0);      run("addi");
        setup(OP_LW, 6'd0, 22'h3FFFFF);     model(OP_LW, 6'd0, 1'b1, 3, 1'b1);        run("lw_io_k3");
        setup(OP_SW, 6'd0, 22'd0);          model(OP_SW, 6'd0, 1'b0, 0, 1'b1);        run("sw_timeout");
        setup(OP_BNE, 6'd0, 22'd0);         model(OP_BNE, 6'd0, 1'b0, 0, 1'b0);       run("bne");
        setup(OP_JAL, 6'd0, 22'd0);         model(OP_JAL, 6'd0, 1'b0, 0, 1'b0);       run("jal");
        setup(OP_BEQ, 6'd0, 22'd0);         model(OP_BEQ, 6'd0, 1'b0, 0, 1'b0);       run("beq");
        setup(OP_J, 6'd0, 22'd0);           model(OP_J, 6'd0, 1'b0, 0, 1'b0);         run("j");
        setup(OP_R, 6'b001000, 22'd0);      model(OP_R, 6'b001000, 1'b0, 0, 1'b0);    run("jr");
        setup(OP_SW, 6'd0, 22'h000123);     model(OP_SW, 6'd0, 1'b0, 1, 1'b0);        run("sw_mem_k1");
        setup(OP_SW, 6'd0, 22'h3FFFFF);     model(OP_SW, 6'd0, 1'b1, 2, 1'b0);        run("sw_io_k2");
        setup(OP_LW, 6'd0, 22'h3FFFFE);     model(OP_LW, 6'd0, 1'b0, TMO, 1'b1);      run("lw_mem_k15");
        setup(OP_LW, 6'd0, 22'h3FFFFF);     model(OP_LW, 6'd0, 1'b1, 0, 1'b1);        run("lw_io_timeout");
        setup(OP_BAD, 6'd0, 22'd0);         model(OP_BAD, 6'd0, 1'b0, 0, 1'b0);       run("illegal");

        setup(OP_LW, 6'd0, 22'd0);          model(OP_LW, 6'd0, 1'b0, 0, 1'b0);
        while (sq.size() > 6) void'(sq.pop_back());
        run("lw_abort");
        do_reset("mid_mem");
        setup(OP_R, 6'b100000, 22'd0);      model(OP_R, 6'b100000, 1'b0, 0, 1'b0);    run("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
